// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice allocator.
package midi_pkg;

    typedef struct packed {
        logic [7:0] status;
        logic [6:0] data1;
        logic [6:0] data2;
        logic [1:0] count;
    } midi_msg_t;

    typedef enum logic [1:0] {IDLE, DECODE, SCAN, COMMIT} alloc_state_t;

    typedef enum logic [1:0] {MSG_NONE, MSG_NOTE_ON, MSG_NOTE_OFF, MSG_ALL_OFF} msg_kind_t;

    localparam logic [3:0] MIDI_NOTE_OFF    = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON     = 4'h9;
    localparam logic [3:0] MIDI_CC          = 4'hB;
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

endpackage

// File: rtl/midi_msg_decode.sv
// Classifies a snapshotted MIDI message into none / note on / note off / all off.
// Define MIDI_VOICE_ALLOFF_EN to recognise CC 120/123 as all off.
module midi_msg_decode
    import midi_pkg::*;
#(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned OMNI    = 0
) (
    input  logic [7:0] status,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    input  logic [1:0] count,
    output logic [1:0] kind
);

    logic chan_ok;

    assign chan_ok = (OMNI != 0) || (status[3:0] == 4'(CHANNEL));

`ifndef MIDI_VOICE_ALLOFF_EN
    logic unused_data1;
    assign unused_data1 = ^data1;
`endif

    always_comb begin
        kind = MSG_NONE;
        if (chan_ok && count == 2'd3) begin
            case (status[7:4])
                // Note On with zero velocity is a Note Off by MIDI convention
                MIDI_NOTE_ON:  kind = (data2 != 7'd0) ? MSG_NOTE_ON : MSG_NOTE_OFF;
                MIDI_NOTE_OFF: kind = MSG_NOTE_OFF;
`ifdef MIDI_VOICE_ALLOFF_EN
                MIDI_CC: begin
                    if (data1 == CC_ALL_SOUND_OFF || data1 == CC_ALL_NOTES_OFF) begin
                        kind = MSG_ALL_OFF;
                    end
                end
`endif
                default:       kind = MSG_NONE;
            endcase
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Note On/Off voice allocator: match first, then free voice, then steal the oldest.
// Define MIDI_VOICE_ALLOFF_EN to release all voices on CC 120/123.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CHANNEL    = 0,
    parameter int unsigned OMNI       = 0
) (
    input  logic                      baud_clk,
    input  logic                      rst,
    input  logic                      completed,
    input  logic [7:0]                status_in,
    input  logic [7:0]                data1_in,
    input  logic [7:0]                data2_in,
    input  logic [1:0]                bytes_cnt_in,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_vel,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t          state;
    midi_msg_t             msg_q;
    logic                  completed_q;
    logic                  accept;
    logic [1:0]            kind;
    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] trig_q;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [7:0]            age_q  [NUM_VOICES];
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      match_idx_q;
    logic [IDX_W-1:0]      free_idx_q;
    logic [IDX_W-1:0]      oldest_idx_q;
    logic [IDX_W-1:0]      target;
    logic [7:0]            oldest_age_q;
    logic                  match_found_q;
    logic                  free_found_q;
    logic                  overrun_q;
    logic                  unused_msb;

    assign unused_msb = data1_in[7] ^ data2_in[7];
    assign accept     = completed && !completed_q;

    midi_msg_decode #(
        .CHANNEL (CHANNEL),
        .OMNI    (OMNI)
    ) u_decode (
        .status (msg_q.status),
        .data1  (msg_q.data1),
        .data2  (msg_q.data2),
        .count  (msg_q.count),
        .kind   (kind)
    );

    always_comb begin
        if (match_found_q) begin
            target = match_idx_q;
        end else if (free_found_q) begin
            target = free_idx_q;
        end else begin
            target = oldest_idx_q;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            msg_q         <= '0;
            completed_q   <= 1'b0;
            gate_q        <= '0;
            trig_q        <= '0;
            idx_q         <= '0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            oldest_idx_q  <= '0;
            oldest_age_q  <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            completed_q <= completed;
            trig_q      <= '0;
            overrun_q   <= accept && (state != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        msg_q.status <= status_in;
                        msg_q.data1  <= data1_in[6:0];
                        msg_q.data2  <= data2_in[6:0];
                        msg_q.count  <= bytes_cnt_in;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    idx_q         <= '0;
                    match_found_q <= 1'b0;
                    free_found_q  <= 1'b0;
                    case (kind)
                        MSG_NOTE_ON, MSG_NOTE_OFF: state <= SCAN;
                        MSG_ALL_OFF:               state <= COMMIT;
                        default:                   state <= IDLE;
                    endcase
                end
                SCAN: begin
                    if (!match_found_q && gate_q[idx_q] && note_q[idx_q] == msg_q.data1) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= idx_q;
                    end
                    if (!free_found_q && !gate_q[idx_q]) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    // strict compare keeps the lowest index on equal ages
                    if (idx_q == '0 || age_q[idx_q] > oldest_age_q) begin
                        oldest_idx_q <= idx_q;
                        oldest_age_q <= age_q[idx_q];
                    end
                    if (idx_q == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    case (kind)
                        MSG_NOTE_OFF: begin
                            if (match_found_q) gate_q[match_idx_q] <= 1'b0;
                        end
                        MSG_NOTE_ON: begin
                            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                                if (IDX_W'(i) == target) begin
                                    note_q[i] <= msg_q.data1;
                                    vel_q[i]  <= msg_q.data2;
                                    age_q[i]  <= 8'd0;
                                    gate_q[i] <= 1'b1;
                                    trig_q[i] <= 1'b1;
                                end else if (gate_q[i] && age_q[i] != 8'hFF) begin
                                    age_q[i] <= age_q[i] + 8'd1;
                                end
                            end
                        end
                        MSG_ALL_OFF: begin
                            gate_q <= '0;
                            for (int i = 0; i < int'(NUM_VOICES); i++) age_q[i] <= 8'd0;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7] = note_q[g];
        assign voice_vel[7*g +: 7]  = vel_q[g];
    end

    assign voice_gate = gate_q;
    assign voice_trig = trig_q;
    assign busy       = (state != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: directed cases, then randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_midi_voice_alloc;

    localparam int NV = 4;
    localparam int CH = 2;

    typedef struct {
        int              acc;
        int              lat;
        logic [NV-1:0]   gate;
        logic [NV-1:0]   trig;
        logic [7*NV-1:0] note;
        logic [7*NV-1:0] vel;
    } exp_t;

    logic            baud_clk = 1'b0;
    logic            rst = 1'b1;
    logic            completed = 1'b0;
    logic [7:0]      status_in = '0;
    logic [7:0]      data1_in = '0;
    logic [7:0]      data2_in = '0;
    logic [1:0]      bytes_cnt_in = '0;
    logic [NV-1:0]   voice_gate, voice_trig;
    logic [7*NV-1:0] voice_note, voice_vel;
    logic            busy, overrun;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   trig0_cnt = 0;
    int   trig_cycles = 0;
    exp_t q[$];
    int   ovq[$];

    int m_gate[NV];
    int m_note[NV];
    int m_vel[NV];
    int m_age[NV];

    midi_voice_alloc #(
        .NUM_VOICES (NV),
        .CHANNEL    (CH),
        .OMNI       (0)
    ) dut (
        .baud_clk     (baud_clk),
        .rst          (rst),
        .completed    (completed),
        .status_in    (status_in),
        .data1_in     (data1_in),
        .data2_in     (data2_in),
        .bytes_cnt_in (bytes_cnt_in),
        .voice_gate   (voice_gate),
        .voice_trig   (voice_trig),
        .voice_note   (voice_note),
        .voice_vel    (voice_vel),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 baud_clk = ~baud_clk;
    always @(posedge baud_clk) cyc <= cyc + 1;

    always @(negedge baud_clk) begin
        if (voice_trig[0]) trig0_cnt <= trig0_cnt + 1;
        if (|voice_trig) trig_cycles <= trig_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: applies one accepted message to the voice pool and records the expectation.
    function automatic void model(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                                  input logic [1:0] cnt, output exp_t e);
        int kind;
        int t;
        kind   = 0;
        e.acc  = 0;
        e.lat  = 1;
        e.trig = '0;
        if (cnt == 2'd3 && int'(st[3:0]) == CH) begin
            if (st[7:4] == 4'h9) kind = (d2 != 0) ? 1 : 2;
            else if (st[7:4] == 4'h8) kind = 2;
`ifdef MIDI_VOICE_ALLOFF_EN
            else if (st[7:4] == 4'hB && (d1 == 7'd120 || d1 == 7'd123)) kind = 3;
`endif
        end
        if (kind == 1 || kind == 2) begin
            e.lat = NV + 2;
            t = -1;
            for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] != 0 && m_note[i] == int'(d1)) t = i;
            if (kind == 2) begin
                if (t >= 0) m_gate[t] = 0;
            end else begin
                for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] == 0) t = i;
                if (t < 0) begin
                    t = 0;
                    for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
                end
                for (int i = 0; i < NV; i++)
                    if (i != t && m_gate[i] != 0 && m_age[i] < 255) m_age[i]++;
                m_age[t]  = 0;
                m_gate[t] = 1;
                m_note[t] = int'(d1);
                m_vel[t]  = int'(d2);
                e.trig[t] = 1'b1;
            end
        end else if (kind == 3) begin
            e.lat = 2;
            for (int i = 0; i < NV; i++) begin
                m_gate[i] = 0;
                m_age[i]  = 0;
            end
        end
        for (int i = 0; i < NV; i++) begin
            e.gate[i]       = (m_gate[i] != 0);
            e.note[7*i +: 7] = 7'(m_note[i]);
            e.vel[7*i +: 7]  = 7'(m_vel[i]);
        end
    endfunction

    function automatic logic [NV-1:0] model_gate();
        logic [NV-1:0] g;
        for (int i = 0; i < NV; i++) g[i] = (m_gate[i] != 0);
        return g;
    endfunction

    // Monitor: pops an expectation whenever busy falls or overrun pulses.
    initial begin : monitor
        logic busy_prev;
        exp_t e;
        int   c;
        busy_prev = 1'b0;
        forever begin
            @(negedge baud_clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (overrun) begin
                    tests++;
                    if (ovq.size() == 0) begin
                        fails++;
                        $display("FAIL overrun: unexpected pulse at cycle %0d", cyc);
                    end else begin
                        c = ovq.pop_front();
                        if (c != cyc) begin
                            fails++;
                            $display("FAIL overrun: pulse at cycle %0d, required %0d", cyc, c);
                        end
                    end
                end
                if (busy_prev && !busy) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL response: unexpected message completion at cycle %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        if (cyc - e.acc != e.lat || voice_gate !== e.gate || voice_trig !== e.trig ||
                            voice_note !== e.note || voice_vel !== e.vel) begin
                            fails++;
                            $display("FAIL response: lat=%0d gate=%b trig=%b note=%h vel=%h, required lat=%0d gate=%b trig=%b note=%h vel=%h",
                                     cyc - e.acc, voice_gate, voice_trig, voice_note, voice_vel,
                                     e.lat, e.gate, e.trig, e.note, e.vel);
                        end
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [1:0] cnt, input int hold, output int acc);
        exp_t e;
        @(negedge baud_clk);
        status_in    = st;
        data1_in     = d1;
        data2_in     = d2;
        bytes_cnt_in = cnt;
        completed    = 1'b1;
        model(st, d1[6:0], d2[6:0], cnt, e);
        acc   = cyc + 1;
        e.acc = acc;
        q.push_back(e);
        repeat (hold) @(negedge baud_clk);
        completed = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || ovq.size() != 0 || busy) && n < 40) begin
            @(negedge baud_clk);
            n++;
        end
        check("completion_timeout", 64'(n >= 40), 64'd0);
        if (n >= 40) begin
            q.delete();
            ovq.delete();
        end
        @(negedge baud_clk);
    endtask

    task automatic msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
        int acc;
        send(st, d1, d2, 2'd3, 1, acc);
        wait_idle();
    endtask

    // Valid scan message, then a second rising edge k cycles after its accept edge.
    task automatic send_ovr(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                            input int k);
        int acc;
        send(st, d1, d2, 2'd3, 1, acc);
        while (cyc + 1 < acc + k) @(negedge baud_clk);
        status_in    = 8'h92;
        data1_in     = 8'($urandom_range(0, 255));
        data2_in     = 8'($urandom_range(1, 127));
        bytes_cnt_in = 2'd3;
        completed    = 1'b1;
        ovq.push_back(cyc + 1);
        @(negedge baud_clk);
        completed = 1'b0;
        wait_idle();
    endtask

    initial begin
        int            acc;
        int            tsnap;
        logic [7:0]    st, d1, d2;
        logic [1:0]    cnt;
        logic [3:0]    typ, ch;
        int            r;

        repeat (3) @(negedge baud_clk);
        check("reset_gate", 64'(voice_gate), 64'd0);
        check("reset_note_vel", 64'(voice_note | voice_vel), 64'd0);
        check("reset_busy_ovr_trig", 64'({busy, overrun, voice_trig}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge baud_clk);

        msg(8'h92, 8'h3C, 8'h64);
        check("first_gate", 64'(voice_gate), 64'b0001);
        check("first_note", 64'(voice_note[6:0]), 64'd60);
        check("first_vel", 64'(voice_vel[6:0]), 64'd100);
        check("first_trig_count", 64'(trig0_cnt), 64'd1);

        msg(8'h92, 8'h3E, 8'h50);
        msg(8'h92, 8'h40, 8'h50);
        msg(8'h92, 8'h41, 8'h50);
        msg(8'h92, 8'h43, 8'h50);
        check("steal_gate", 64'(voice_gate), 64'hF);
        check("steal_notes", 64'(voice_note), 64'({7'd65, 7'd64, 7'd62, 7'd67}));
        check("steal_trig0_count", 64'(trig0_cnt), 64'd2);

        msg(8'h92, 8'h3E, 8'h00);
        check("vel0_off_gate", 64'(voice_gate), 64'b1101);
        check("vel0_off_note_kept", 64'(voice_note[13:7]), 64'd62);
        msg(8'h92, 8'h45, 8'h30);
        check("reuse_free_note", 64'(voice_note[13:7]), 64'd69);
        msg(8'h92, 8'h40, 8'h11);
        check("dup_gate", 64'(voice_gate), 64'hF);
        check("dup_retrigger_vel", 64'(voice_vel[20:14]), 64'h11);

        msg(8'h93, 8'h3C, 8'h64);
        check("wrong_channel_gate", 64'(voice_gate), 64'hF);

        send_ovr(8'h92, 8'h30, 8'h40, 3);
        send_ovr(8'h82, 8'h30, 8'h40, NV + 2);

        msg(8'hB2, 8'h7B, 8'h00);
`ifdef MIDI_VOICE_ALLOFF_EN
        check("all_notes_off_gate", 64'(voice_gate), 64'd0);
`else
        check("cc_ignored_gate", 64'(voice_gate), 64'(model_gate()));
`endif

        send(8'h92, 8'h3C, 8'h22, 2'd3, 12, acc);
        wait_idle();

        // Reset in the middle of a scan
        send(8'h92, 8'h50, 8'h22, 2'd3, 1, acc);
        repeat (2) @(negedge baud_clk);
        @(posedge baud_clk);
        #2 rst = 1'b1;
        @(negedge baud_clk);
        check("midscan_reset_gate", 64'(voice_gate), 64'd0);
        check("midscan_reset_busy", 64'({busy, voice_trig}), 64'd0);
        q.delete();
        ovq.delete();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0;
            m_note[i] = 0;
            m_vel[i]  = 0;
            m_age[i]  = 0;
        end
        tsnap = trig_cycles;
        @(negedge baud_clk);
        rst = 1'b0;
        repeat (NV + 4) @(negedge baud_clk);
        check("no_trig_after_reset", 64'(trig_cycles - tsnap), 64'd0);

        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, 9);
            ch  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(CH);
            typ = (r < 5) ? 4'h9 : (r < 8) ? 4'h8 : (r == 8) ? 4'hB : 4'($urandom_range(0, 15));
            st  = {typ, ch};
            d1  = {1'($urandom_range(0, 1)), 7'(60 + $urandom_range(0, 7))};
            if (typ == 4'hB) begin
                case ($urandom_range(0, 2))
                    0:       d1 = 8'd120;
                    1:       d1 = 8'd123;
                    default: d1 = 8'($urandom_range(0, 127));
                endcase
            end
            d2  = {1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127))};
            cnt = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 2)) : 2'd3;
            if (n % 8 == 7) begin
                send_ovr({($urandom_range(0, 1) == 0) ? 4'h9 : 4'h8, 4'(CH)}, d1, d2,
                         $urandom_range(2, NV + 2));
            end else begin
                send(st, d1, d2, cnt, $urandom_range(1, 3), acc);
                wait_idle();
            end
        end

        check("scoreboard_drained", 64'(q.size() + ovq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
